// File: rtl/marc_pkg.sv
// Shared encodings for the mARC multi-cycle control unit: FSM states, opcodes,
// branch conditions, PC/writeback selects and trap causes.
package marc_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [4:0] OP_ALUCC = 5'b00101;
    localparam logic [4:0] OP_LD    = 5'b00110;
    localparam logic [4:0] OP_ST    = 5'b00111;
    localparam logic [4:0] OP_BR    = 5'b01001;
    localparam logic [4:0] OP_SETLO = 5'b01010;
    localparam logic [4:0] OP_SETHI = 5'b01011;
    localparam logic [4:0] OP_CALL  = 5'b11111;

    localparam logic [2:0] COND_JMPL = 3'b000;
    localparam logic [2:0] COND_BA   = 3'b001;
    localparam logic [2:0] COND_BE   = 3'b010;
    localparam logic [2:0] COND_BNE  = 3'b011;
    localparam logic [2:0] COND_BNEG = 3'b100;
    localparam logic [2:0] COND_BCS  = 3'b101;
    localparam logic [2:0] COND_BVS  = 3'b110;
    localparam logic [2:0] COND_ILL  = 3'b111;

    localparam logic [1:0] PC_HOLD   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_REG    = 2'b10;
    localparam logic [1:0] PC_TRAP   = 2'b11;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b10;
    localparam logic [1:0] WB_IMM  = 2'b11;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
    localparam logic [1:0] CAUSE_IRQ     = 2'b11;

endpackage

// File: rtl/marc_branch_eval.sv
// Branch condition evaluator: PSR flags + 3-bit condition -> taken / illegal.
module marc_branch_eval
    import marc_pkg::*;
(
    input  logic [2:0] i_cond,
    input  logic [3:0] i_flags,      // [3]=N [2]=Z [1]=V [0]=C
    output logic       o_taken,
    output logic       o_illegal
);

    always_comb begin
        o_taken   = 1'b0;
        o_illegal = 1'b0;
        case (i_cond)
            COND_JMPL: o_taken = 1'b1;
            COND_BA:   o_taken = 1'b1;
            COND_BE:   o_taken = i_flags[2];
            COND_BNE:  o_taken = ~i_flags[2];
            COND_BNEG: o_taken = i_flags[3];
            COND_BCS:  o_taken = i_flags[0];
            COND_BVS:  o_taken = i_flags[1];
            default:   o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/marc_mc_control.sv
// mARC multi-cycle control unit: fetch/decode/exec/mem/wb sequencing with a
// timed-out memory handshake, branch evaluation and trap generation.
module marc_mc_control
    import marc_pkg::*;
#(
    parameter int IW          = 16,
    parameter int OPW         = 5,
    parameter int ALUW        = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int TOW         = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [IW-1:0]   i_instruction,
    input  logic [4:0]      i_status,
    input  logic            i_mem_ready,
    input  logic            i_irq,
    output logic            o_mem_req,
    output logic            o_rw_mem,
    output logic            o_ir_load,
    output logic            o_pc_inc,
    output logic [1:0]      o_pc_sel,
    output logic            o_reg_we,
    output logic [1:0]      o_wb_sel,
    output logic [ALUW-1:0] o_alu_op,
    output logic            o_psr_we,
    output logic            o_trap,
    output logic [1:0]      o_trap_cause
);

    state_t         r_state;
    state_t         w_next;
    logic [TOW-1:0] r_count;
    logic [1:0]     r_trap_cause;

    logic [OPW-1:0] w_opcode;
    logic           w_taken;
    logic           w_cond_ill;
    logic           w_timeout;
    logic           w_wait;
    logic [1:0]     w_cause;
    state_t         w_ret_state;
    logic [1:0]     w_ret_cause;
    logic           w_unused;

    assign w_opcode  = i_instruction[IW-1 -: OPW];
    assign w_timeout = (r_count == TOW'(MEM_TIMEOUT - 1));
    assign w_unused  = ^i_instruction;

    marc_branch_eval u_branch_eval (
        .i_cond    (i_instruction[10:8]),
        .i_flags   (i_status[3:0]),
        .o_taken   (w_taken),
        .o_illegal (w_cond_ill)
    );

    // Every completed instruction returns to FETCH unless an enabled irq diverts it.
    always_comb begin
        w_ret_state = S_FETCH;
        w_ret_cause = CAUSE_NONE;
        if (i_irq && i_status[4]) begin
            w_ret_state = S_TRAP;
            w_ret_cause = CAUSE_IRQ;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_cause   = CAUSE_NONE;
        w_wait    = 1'b0;
        o_mem_req = 1'b0;
        o_rw_mem  = 1'b0;
        o_ir_load = 1'b0;
        o_pc_inc  = 1'b0;
        o_pc_sel  = PC_HOLD;
        o_reg_we  = 1'b0;
        o_wb_sel  = WB_ALU;
        o_alu_op  = '0;
        o_psr_we  = 1'b0;
        o_trap    = 1'b0;
        if (!i_reset) begin
            case (r_state)
                S_FETCH: begin
                    o_mem_req = 1'b1;
                    if (i_mem_ready) begin
                        o_ir_load = 1'b1;
                        o_pc_inc  = 1'b1;
                        w_next    = S_DECODE;
                    end else if (w_timeout) begin
                        w_next  = S_TRAP;
                        w_cause = CAUSE_TIMEOUT;
                    end else begin
                        w_wait = 1'b1;
                    end
                end
                S_DECODE: begin
                    case (w_opcode)
                        OPW'(OP_ALUCC), OPW'(OP_SETLO),
                        OPW'(OP_SETHI), OPW'(OP_CALL): w_next = S_EXEC;
                        OPW'(OP_LD), OPW'(OP_ST):      w_next = S_MEM;
                        OPW'(OP_BR): begin
                            if (w_cond_ill) begin
                                w_next  = S_TRAP;
                                w_cause = CAUSE_ILLEGAL;
                            end else begin
                                w_next = S_EXEC;
                            end
                        end
                        default: begin
                            w_next  = S_TRAP;
                            w_cause = CAUSE_ILLEGAL;
                        end
                    endcase
                end
                S_EXEC: begin
                    case (w_opcode)
                        OPW'(OP_ALUCC): begin
                            o_reg_we = 1'b1;
                            o_wb_sel = WB_ALU;
                            o_psr_we = 1'b1;
                            o_alu_op = i_instruction[ALUW-1:0];
                        end
                        OPW'(OP_SETLO), OPW'(OP_SETHI): begin
                            o_reg_we = 1'b1;
                            o_wb_sel = WB_IMM;
                        end
                        OPW'(OP_CALL): begin
                            o_reg_we = 1'b1;
                            o_wb_sel = WB_LINK;
                            o_pc_sel = PC_BRANCH;
                        end
                        OPW'(OP_BR): begin
                            if (i_instruction[10:8] == COND_JMPL) begin
                                o_pc_sel = PC_REG;
                                o_reg_we = 1'b1;
                                o_wb_sel = WB_LINK;
                            end else if (w_taken) begin
                                o_pc_sel = PC_BRANCH;
                            end
                        end
                        default: ;
                    endcase
                    w_next  = w_ret_state;
                    w_cause = w_ret_cause;
                end
                S_MEM: begin
                    o_mem_req = 1'b1;
                    o_rw_mem  = (w_opcode == OPW'(OP_ST));
                    if (i_mem_ready) begin
                        if (w_opcode == OPW'(OP_ST)) begin
                            w_next  = w_ret_state;
                            w_cause = w_ret_cause;
                        end else begin
                            w_next = S_WB;
                        end
                    end else if (w_timeout) begin
                        w_next  = S_TRAP;
                        w_cause = CAUSE_TIMEOUT;
                    end else begin
                        w_wait = 1'b1;
                    end
                end
                S_WB: begin
                    o_reg_we = 1'b1;
                    o_wb_sel = WB_MEM;
                    w_next   = w_ret_state;
                    w_cause  = w_ret_cause;
                end
                S_TRAP: begin
                    o_trap   = 1'b1;
                    o_pc_sel = PC_TRAP;
                    w_next   = S_FETCH;
                end
                default: w_next = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_FETCH;
            r_count      <= '0;
            r_trap_cause <= CAUSE_NONE;
        end else begin
            r_state <= w_next;
            // Waiting only happens while staying put, so any state change clears the count.
            if (w_wait) r_count <= r_count + TOW'(1);
            else        r_count <= '0;
            if (w_next == S_TRAP && r_state != S_TRAP) r_trap_cause <= w_cause;
        end
    end

    assign o_trap_cause = r_trap_cause;

endmodule

// File: tb/tb_marc_mc_control.sv
// Self-checking bench for marc_mc_control: directed table, reset-mid-access
// sequence and randomized instructions against a transaction-level model.
module tb_marc_mc_control;

    localparam int MT = 15;

    logic        clk = 1'b0;
    logic        i_reset;
    logic [15:0] i_instruction;
    logic [4:0]  i_status;
    logic        i_mem_ready;
    logic        i_irq;
    logic        o_mem_req, o_rw_mem, o_ir_load, o_pc_inc, o_reg_we, o_psr_we, o_trap;
    logic [1:0]  o_pc_sel, o_wb_sel, o_trap_cause;
    logic [3:0]  o_alu_op;

    always #5 clk = ~clk;

    marc_mc_control #(.IW(16), .OPW(5), .ALUW(4), .MEM_TIMEOUT(MT), .TOW(4)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_instruction(i_instruction),
        .i_status(i_status), .i_mem_ready(i_mem_ready), .i_irq(i_irq),
        .o_mem_req(o_mem_req), .o_rw_mem(o_rw_mem), .o_ir_load(o_ir_load),
        .o_pc_inc(o_pc_inc), .o_pc_sel(o_pc_sel), .o_reg_we(o_reg_we),
        .o_wb_sel(o_wb_sel), .o_alu_op(o_alu_op), .o_psr_we(o_psr_we),
        .o_trap(o_trap), .o_trap_cause(o_trap_cause)
    );

    typedef struct packed {
        logic       req;
        logic       rw;
        logic       irl;
        logic       pci;
        logic [1:0] pcs;
        logic       rwe;
        logic [1:0] wbs;
        logic [3:0] alu;
        logic       psr;
        logic       trp;
        logic [1:0] cause;
    } outv_t;

    typedef struct {
        logic  rdy;
        outv_t exp;
    } cyc_t;

    typedef struct {
        string       name;
        logic [15:0] ins;
        logic [4:0]  st;
        logic        irq;
        int          fw;
        int          mw;
        int          key;
        outv_t       kexp;
    } vec_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [1:0] m_cause;
    cyc_t       q[$];
    outv_t      obs[0:63];
    vec_t       tbl[12];

    function automatic outv_t mkv(logic req, logic rw, logic irl, logic pci, logic [1:0] pcs,
                                  logic rwe, logic [1:0] wbs, logic [3:0] alu, logic psr,
                                  logic trp, logic [1:0] cause);
        outv_t v;
        v = {req, rw, irl, pci, pcs, rwe, wbs, alu, psr, trp, cause};
        return v;
    endfunction

    function automatic outv_t sample();
        outv_t v;
        v = {o_mem_req, o_rw_mem, o_ir_load, o_pc_inc, o_pc_sel, o_reg_we, o_wb_sel,
             o_alu_op, o_psr_we, o_trap, o_trap_cause};
        return v;
    endfunction

    task automatic check(input string name, input outv_t act, input outv_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic push(input logic rdy, input outv_t v);
        cyc_t c;
        c.rdy = rdy;
        c.exp = v;
        q.push_back(c);
    endtask

    task automatic push_trap(input logic [1:0] cause);
        m_cause = cause;
        push(1'($urandom_range(0, 1)), mkv(0, 0, 0, 0, 2'b11, 0, 2'b00, 4'h0, 0, 1, cause));
    endtask

    // A memory access: w idle cycles then ready, or a timeout after MT unanswered cycles.
    task automatic mem_phase(input int w, input logic rw, input logic fetch, output bit ok);
        if (w >= MT) begin
            for (int i = 0; i < MT; i++)
                push(1'b0, mkv(1, rw, 0, 0, 2'b00, 0, 2'b00, 4'h0, 0, 0, m_cause));
            push_trap(2'b10);
            ok = 1'b0;
        end else begin
            for (int i = 0; i < w; i++)
                push(1'b0, mkv(1, rw, 0, 0, 2'b00, 0, 2'b00, 4'h0, 0, 0, m_cause));
            push(1'b1, mkv(1, rw, fetch, fetch, 2'b00, 0, 2'b00, 4'h0, 0, 0, m_cause));
            ok = 1'b1;
        end
    endtask

    // Expected per-cycle outputs for one instruction, from FETCH entry to the next FETCH.
    task automatic build(input logic [15:0] ins, input logic [4:0] st, input logic irq,
                         input int fw, input int mw);
        logic [4:0] op;
        logic [2:0] cond;
        logic       legal, taken;
        bit         ok;
        outv_t      v;
        op   = ins[15:11];
        cond = ins[10:8];
        q.delete();
        mem_phase(fw, 1'b0, 1'b1, ok);
        if (!ok) return;
        push(1'($urandom_range(0, 1)), mkv(0, 0, 0, 0, 2'b00, 0, 2'b00, 4'h0, 0, 0, m_cause));
        legal = (op == 5'b00101 || op == 5'b00110 || op == 5'b00111 || op == 5'b01010 ||
                 op == 5'b01011 || op == 5'b11111 || (op == 5'b01001 && cond != 3'b111));
        if (!legal) begin
            push_trap(2'b01);
            return;
        end
        if (op == 5'b00110 || op == 5'b00111) begin
            mem_phase(mw, (op == 5'b00111), 1'b0, ok);
            if (!ok) return;
            if (op == 5'b00110)
                push(1'($urandom_range(0, 1)), mkv(0, 0, 0, 0, 2'b00, 1, 2'b01, 4'h0, 0, 0, m_cause));
        end else begin
            v = mkv(0, 0, 0, 0, 2'b00, 0, 2'b00, 4'h0, 0, 0, m_cause);
            case (op)
                5'b00101: begin v.rwe = 1; v.psr = 1; v.alu = ins[3:0]; end
                5'b01010, 5'b01011: begin v.rwe = 1; v.wbs = 2'b11; end
                5'b11111: begin v.rwe = 1; v.wbs = 2'b10; v.pcs = 2'b01; end
                default: begin
                    case (cond)
                        3'd1: taken = 1;
                        3'd2: taken = st[2];
                        3'd3: taken = !st[2];
                        3'd4: taken = st[3];
                        3'd5: taken = st[0];
                        3'd6: taken = st[1];
                        default: taken = 0;
                    endcase
                    if (cond == 3'd0) begin v.pcs = 2'b10; v.rwe = 1; v.wbs = 2'b10; end
                    else if (taken) v.pcs = 2'b01;
                end
            endcase
            push(1'($urandom_range(0, 1)), v);
        end
        if (irq && st[4]) push_trap(2'b11);
    endtask

    task automatic run_txn(input string name, input logic [15:0] ins, input logic [4:0] st,
                           input logic irq, input int fw, input int mw);
        outv_t v;
        build(ins, st, irq, fw, mw);
        i_instruction = ins;
        i_status      = st;
        i_irq         = irq;
        for (int i = 0; i < q.size(); i++) begin
            i_mem_ready = q[i].rdy;
            #1;
            v = sample();
            if (i < 64) obs[i] = v;
            check($sformatf("%s cyc%0d", name, i), v, q[i].exp);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] rnd;
        logic [4:0]  op;
        int          fw, mw;

        tbl[0]  = '{"subcc",     16'b0010111100010011, 5'b00000, 0, 0, 0, 2,
                    mkv(0, 0, 0, 0, 2'b00, 1, 2'b00, 4'b0011, 1, 0, 2'b00)};
        tbl[1]  = '{"ld_wait2",  16'b0011011100000001, 5'b00000, 0, 0, 2, 5,
                    mkv(0, 0, 0, 0, 2'b00, 1, 2'b01, 4'h0, 0, 0, 2'b00)};
        tbl[2]  = '{"st_wait2",  16'b0011111100010001, 5'b00000, 0, 0, 2, 4,
                    mkv(1, 1, 0, 0, 2'b00, 0, 2'b00, 4'h0, 0, 0, 2'b00)};
        tbl[3]  = '{"be_z1",     16'b0100101000000100, 5'b00100, 0, 0, 0, 2,
                    mkv(0, 0, 0, 0, 2'b01, 0, 2'b00, 4'h0, 0, 0, 2'b00)};
        tbl[4]  = '{"be_z0",     16'b0100101000000100, 5'b01011, 0, 1, 0, 3,
                    mkv(0, 0, 0, 0, 2'b00, 0, 2'b00, 4'h0, 0, 0, 2'b00)};
        tbl[5]  = '{"setlow_ie0", 16'b0101011111111111, 5'b00000, 1, 0, 0, 2,
                    mkv(0, 0, 0, 0, 2'b00, 1, 2'b11, 4'h0, 0, 0, 2'b00)};
        tbl[6]  = '{"illegal_op", 16'b0000000000000000, 5'b00000, 0, 0, 0, 2,
                    mkv(0, 0, 0, 0, 2'b11, 0, 2'b00, 4'h0, 0, 1, 2'b01)};
        tbl[7]  = '{"cond111",   16'b0100111100000000, 5'b00000, 0, 0, 0, 2,
                    mkv(0, 0, 0, 0, 2'b11, 0, 2'b00, 4'h0, 0, 1, 2'b01)};
        tbl[8]  = '{"fetch_to",  16'b0010100000000000, 5'b00000, 0, MT, 0, MT,
                    mkv(0, 0, 0, 0, 2'b11, 0, 2'b00, 4'h0, 0, 1, 2'b10)};
        tbl[9]  = '{"setlow_irq", 16'b0101011111111111, 5'b10000, 1, 0, 0, 3,
                    mkv(0, 0, 0, 0, 2'b11, 0, 2'b00, 4'h0, 0, 1, 2'b11)};
        tbl[10] = '{"jmpl",      16'b0100100000000000, 5'b00000, 0, 0, 0, 2,
                    mkv(0, 0, 0, 0, 2'b10, 1, 2'b10, 4'h0, 0, 0, 2'b11)};
        tbl[11] = '{"call",      16'b1111100000000000, 5'b00000, 0, 0, 0, 2,
                    mkv(0, 0, 0, 0, 2'b01, 1, 2'b10, 4'h0, 0, 0, 2'b11)};

        i_reset = 1'b1; i_instruction = '0; i_status = '0; i_mem_ready = 1'b0; i_irq = 1'b0;
        m_cause = 2'b00;
        #2;
        check("reset_outputs", sample(), '0);
        @(negedge clk);
        i_reset = 1'b0;

        foreach (tbl[k]) begin
            run_txn(tbl[k].name, tbl[k].ins, tbl[k].st, tbl[k].irq, tbl[k].fw, tbl[k].mw);
            check({tbl[k].name, " key"}, obs[tbl[k].key], tbl[k].kexp);
        end

        // Reset in the middle of a load's memory wait.
        i_instruction = 16'b0011011100000001; i_status = '0; i_irq = 1'b0; i_mem_ready = 1'b1;
        @(negedge clk);
        i_mem_ready = 1'b0;
        @(negedge clk);
        #1;
        check("ld_in_mem", sample(), mkv(1, 0, 0, 0, 2'b00, 0, 2'b00, 4'h0, 0, 0, m_cause));
        i_reset = 1'b1;
        #1;
        check("reset_mid_mem", sample(), '0);
        @(negedge clk);
        i_reset = 1'b0;
        m_cause = 2'b00;
        #1;
        check("after_reset_fetch", sample(), mkv(1, 0, 0, 0, 2'b00, 0, 2'b00, 4'h0, 0, 0, 2'b00));

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 9))
                0: op = 5'b00101;
                1: op = 5'b00110;
                2: op = 5'b00111;
                3: op = 5'b01001;
                4: op = 5'b01010;
                5: op = 5'b01011;
                6: op = 5'b11111;
                default: op = 5'($urandom_range(0, 31));
            endcase
            rnd = $urandom();
            fw = ($urandom_range(0, 15) == 0) ? MT : $urandom_range(0, 3);
            mw = ($urandom_range(0, 15) == 0) ? MT + 2 : $urandom_range(0, 3);
            run_txn($sformatf("rand%0d", n), {op, rnd[10:0]}, 5'($urandom_range(0, 31)),
                    ($urandom_range(0, 3) == 0), fw, mw);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/marc_mc_control.md
Name: marc_mc_control

Overview:
- Parametrised, multi-cycle successor to the mARC single-cycle control unit.
- Sequences fetch/decode/execute/memory/writeback for the 16-bit mARC ISA. Memory runs behind a variable-latency req/ready handshake with timeout.
- Evaluates conditional branches from PSR flags, and raises traps for illegal opcodes, memory timeout and interrupts.
- Sits between instruction register/PSR and the datapath/memory interface; drives decoded strobes in place of a flat control word.

Parameters:
IW, 16, instruction width
OPW, 5, opcode width; opcode = instruction[IW-1 -: OPW]
ALUW, 4, alu_op width
MEM_TIMEOUT, 15, max cycles mem_req may wait for mem_ready before trap (>=1)
TOW, 4, timeout counter width; must hold MEM_TIMEOUT

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
instruction  in  IW  current IR contents (valid from DECODE onward)
status  in  5  PSR: [3]=N [2]=Z [1]=V [0]=C [4]=interrupt enable
mem_ready  in  1  memory completes the current request this cycle
irq  in  1  level interrupt request
mem_req  out  1  memory access request
rw_mem  out  1  1=write, 0=read; valid when mem_req=1
ir_load  out  1  latch fetched word into IR
pc_inc  out  1  PC <= PC+1
pc_sel  out  2  00 hold/inc, 01 branch target, 10 register (jmpl), 11 trap vector
reg_we  out  1  register-file write
wb_sel  out  2  00 ALU, 01 memory, 10 PC link, 11 immediate (setlow/sethi)
alu_op  out  ALUW  instruction[3:0] for ALUcc, 0000 (add) otherwise
psr_we  out  1  update PSR flags
trap  out  1  one-cycle trap pulse
trap_cause  out  2  01 illegal, 10 mem timeout, 11 irq; held until next trap

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset (async) -> FETCH; all outputs 0, trap_cause=00, timeout counter 0. Assertion mid-access drops mem_req immediately.
- FETCH:
  - mem_req=1, rw_mem=0.
  - On mem_ready: ir_load=1, pc_inc=1 -> DECODE.
  - Otherwise increment counter; counter reaching MEM_TIMEOUT with no ready -> TRAP cause 10.
  - Counter clears on every state entry.
- DECODE, by opcode:
  - 00101 ALUcc -> EXEC.
  - 00110 LD -> MEM.
  - 00111 ST -> MEM.
  - 01001 branch -> EXEC.
  - 01010 setlow -> EXEC.
  - 01011 sethi -> EXEC.
  - 11111 call -> EXEC.
  - Any other opcode -> TRAP cause 01.
- Branch cond = instruction[10:8]:
  - 000 jmpl: always; pc_sel=10, reg_we, wb_sel=10.
  - 001 ba: always.
  - 010 be: Z.
  - 011 bne: !Z.
  - 100 bneg: N.
  - 101 bcs: C.
  - 110 bvs: V.
  - 111: illegal -> TRAP cause 01 from DECODE.
- EXEC (one cycle):
  - ALUcc: reg_we=1, wb_sel=00, psr_we=1.
  - setlow/sethi: reg_we=1, wb_sel=11.
  - call: reg_we=1, wb_sel=10, pc_sel=01.
  - branch: pc_sel=01 if taken, else 00.
  - Then -> FETCH.
- MEM:
  - mem_req=1, rw_mem=1 for ST, 0 for LD.
  - On mem_ready: ST -> FETCH, LD -> WB.
  - Same timeout rule as FETCH (cause 10).
- WB: reg_we=1, wb_sel=01 -> FETCH.
- Latency with mem_ready=1 on first request cycle: ALU/branch/set/call 3 cycles, ST 3, LD 4. Each wait cycle adds 1.
- Interrupt check:
  - On any transition into FETCH, if irq && status[4] -> TRAP cause 11 instead.
  - A trap in progress is never interrupted.
- TRAP: one cycle; trap=1, pc_sel=11, reg_we=0, psr_we=0 -> FETCH (irq not rechecked on this transition).
- mem_ready outside FETCH/MEM is ignored. All strobes are Moore outputs of state+IR except ir_load/pc_inc, which are gated by mem_ready.

Decomposition:
- Shared package marc_pkg: state enum, opcode constants, cond codes, pc_sel/wb_sel encodings, trap causes.
- One sub-module: marc_branch_eval (combinational cond+status -> taken, illegal flag).

Test Plan:
- subcc 16'b0010111100010011, mem_ready=1 -> FETCH,DECODE,EXEC; EXEC cycle reg_we=1, psr_we=1, alu_op=4'b0011; back in FETCH on cycle 4.
- ld 16'b0011011100000001 with mem_ready low 2 cycles in MEM -> mem_req=1, rw_mem=0 for 3 MEM cycles; WB reg_we=1, wb_sel=01; total 6 cycles. Repeat as st 16'b0011111100010001 -> rw_mem=1, no WB.
- be 16'b0100101000000100 with status Z=1 -> EXEC pc_sel=01. With Z=0 -> pc_sel=00.
- Opcode 5'b00000, and branch cond 111 -> trap=1 one cycle, trap_cause=01, pc_sel=11, then FETCH.
- mem_ready held 0 in FETCH -> trap on cycle MEM_TIMEOUT, cause=10. Reset asserted mid-MEM -> mem_req=0 same cycle, state FETCH.
- irq=1, status[4]=1 during EXEC of setlow 16'b0101011111111111 -> TRAP cause 11 next cycle. With status[4]=0 -> normal FETCH.
